// File: rtl/hiscore_upload_reader.sv
// Serves HPS upload reads (high-score / NVRAM save) from core work RAM.
// The game CPU is paused for the whole session so the RAM contents stay stable.
module hiscore_upload_reader #(
  parameter int AW           = 10,
  parameter int SIZE         = 1024,
  parameter int RAM_LATENCY  = 2,
  parameter int PAUSE_SETTLE = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_cpu,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          upload_done,
  output logic [2:0]    state_dbg
);

  // Handshake: ioctl_rd is a one-cycle strobe. From the edge that samples it,
  // ioctl_din is valid only while ioctl_wait is low. An in-range read raises
  // ioctl_wait on that edge. ioctl_din is loaded on the same edge that lowers
  // ioctl_wait. An out-of-range read leaves ioctl_wait low.
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_READY, S_READ, S_DRAIN, S_RELEASE
  } state_t;

  localparam logic [24:0] SIZE_W   = 25'(SIZE);
  localparam logic [3:0]  SETTLE_W = 4'(PAUSE_SETTLE);
  localparam logic [3:0]  LAT_W    = 4'(RAM_LATENCY);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        upload_q;
  logic        rise_pend;
  logic        pend;
  logic [24:0] pend_addr;
  logic        drain_rd;

  logic        rise, start, req, in_range, serve, cnt_zero;
  logic [24:0] req_addr;

  always_comb begin
    rise     = ioctl_upload & ~upload_q;
    start    = rise | rise_pend;
    req      = ioctl_rd | pend;
    // A fresh strobe wins over an older pending request.
    req_addr = ioctl_rd ? ioctl_addr : pend_addr;
    in_range = req_addr < SIZE_W;
    cnt_zero = (cnt == 4'd0);
    serve    = ioctl_upload && req &&
               (state == S_READY || (state == S_SETTLE && cnt_zero));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_SETTLE;
      S_SETTLE: begin
        if (!ioctl_upload)  state_n = S_DRAIN;
        else if (cnt_zero)  state_n = (req && in_range) ? S_READ : S_READY;
      end
      S_READY: begin
        if (!ioctl_upload)          state_n = S_RELEASE;
        else if (req && in_range)   state_n = S_READ;
      end
      S_READ: begin
        if (cnt_zero)           state_n = S_READY;
        else if (!ioctl_upload) state_n = S_DRAIN;
      end
      S_DRAIN:   if (!drain_rd || cnt_zero) state_n = S_RELEASE;
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt         <= '0;
      upload_q    <= 1'b0;
      rise_pend   <= 1'b0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      drain_rd    <= 1'b0;
      ioctl_din   <= '0;
      ioctl_wait  <= 1'b0;
      pause_cpu   <= 1'b0;
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      upload_done <= 1'b0;
    end else begin
      upload_q    <= ioctl_upload;
      ram_rd      <= 1'b0;
      upload_done <= 1'b0;
      // A new session requested while closing the old one starts from IDLE.
      if (rise && (state == S_DRAIN || state == S_RELEASE)) rise_pend <= 1'b1;
      else if (state == S_IDLE)                            rise_pend <= 1'b0;

      if (serve) begin
        pend <= 1'b0;
        if (in_range) begin
          ram_addr   <= req_addr[AW-1:0];
          ram_rd     <= 1'b1;
          ioctl_wait <= 1'b1;
          cnt        <= LAT_W;
        end else begin
          ioctl_din  <= 8'h00;
          ioctl_wait <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              pause_cpu <= 1'b1;
              cnt       <= SETTLE_W;
            end
          end
          S_SETTLE: begin
            if (!ioctl_upload) begin
              drain_rd   <= 1'b0;
              pend       <= 1'b0;
              ioctl_wait <= 1'b0;
            end else begin
              if (!cnt_zero) cnt <= cnt - 4'd1;
              if (ioctl_rd) begin
                pend       <= 1'b1;
                pend_addr  <= ioctl_addr;
                ioctl_wait <= 1'b1;
              end
            end
          end
          S_READ: begin
            if (cnt_zero) begin
              ioctl_din  <= ram_q;
              ioctl_wait <= ioctl_upload && (pend || ioctl_rd);
            end else begin
              cnt <= cnt - 4'd1;
            end
            if (!ioctl_upload) begin
              drain_rd <= 1'b1;
            end else if (ioctl_rd) begin
              pend      <= 1'b1;
              pend_addr <= ioctl_addr;
            end
          end
          S_DRAIN: begin
            pend <= 1'b0;
            if (!drain_rd || cnt_zero) begin
              if (drain_rd) ioctl_din <= ram_q;
              ioctl_wait <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_RELEASE: begin
            pause_cpu   <= 1'b0;
            upload_done <= 1'b1;
            pend        <= 1'b0;
            drain_rd    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hiscore_upload_reader.sv
// Directed bench for hiscore_upload_reader: table of single reads plus
// hand-written session sequences (settle-time read, drain, mid-read reset).
module tb_hiscore_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_cpu;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        busy;
  logic        upload_done;
  logic [2:0]  state_dbg;

  always #5 clk_sys = ~clk_sys;

  hiscore_upload_reader dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_cpu    (pause_cpu),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .busy         (busy),
    .upload_done  (upload_done),
    .state_dbg    (state_dbg)
  );

  // Work RAM model: two-cycle read pipeline from ram_addr.
  logic [7:0] mem [0:1023];
  logic [7:0] ram_s1;
  always @(posedge clk_sys) begin
    ram_s1 <= mem[ram_addr];
    ram_q  <= ram_s1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One strobe, then follow ioctl_wait until it drops (bounded).
  task automatic do_read(input logic [24:0] a, output int wcyc, output int rdc, output bit tmo);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    wcyc = 0;
    rdc  = 0;
    tmo  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ram_rd) rdc++;
      if (!ioctl_wait) begin
        tmo = 1'b0;
        break;
      end
      wcyc++;
      tick();
    end
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          wcyc;
    int          rdc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int  w, r, dly;
    bit  t, seen;

    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[10'h012] = 8'hA5;
    mem[10'h001] = 8'h3C;
    mem[10'h3FF] = 8'h5A;
    mem[10'h000] = 8'hC3;
    mem[10'h3FE] = 8'h7E;

    vecs[0] = '{25'h0000012,  8'hA5, 3, 1};
    vecs[1] = '{25'h0000400,  8'h00, 0, 0};
    vecs[2] = '{25'h00003FF,  8'h5A, 3, 1};
    vecs[3] = '{25'h1000012,  8'h00, 0, 0};
    vecs[4] = '{25'h0000000,  8'hC3, 3, 1};
    vecs[5] = '{25'h1FFFFFF,  8'h00, 0, 0};
    vecs[6] = '{25'h00003FE,  8'h7E, 3, 1};

    // Reset state
    repeat (3) tick();
    check("rst_din",   32'(ioctl_din), 32'h0);
    check("rst_wait",  32'(ioctl_wait), 32'h0);
    check("rst_pause", 32'(pause_cpu), 32'h0);
    check("rst_ramrd", 32'(ram_rd), 32'h0);
    check("rst_raddr", 32'(ram_addr), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(upload_done), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    reset = 1'b0;
    tick();

    // Read strobed one cycle after the upload rises, while still settling
    ioctl_upload = 1'b1;
    tick();
    check("rise_pause", 32'(pause_cpu), 32'h1);
    check("rise_busy",  32'(busy), 32'h1);
    do_read(25'h001, w, r, t);
    check("settle_din",  32'(ioctl_din), 32'h3C);
    check("settle_wcyc", 32'(w), 32'd7);
    check("settle_rdc",  32'(r), 32'd1);
    check("settle_tmo",  32'(t), 32'h0);

    // Table of single reads, in range and out of range
    for (int i = 0; i < 7; i++) begin
      do_read(vecs[i].addr, w, r, t);
      check($sformatf("vec%0d_din", i),  32'(ioctl_din), 32'(vecs[i].din));
      check($sformatf("vec%0d_wcyc", i), 32'(w), 32'(vecs[i].wcyc));
      check($sformatf("vec%0d_rdc", i),  32'(r), 32'(vecs[i].rdc));
      check($sformatf("vec%0d_tmo", i),  32'(t), 32'h0);
    end

    // Full sequential dump against the RAM image
    for (int a = 0; a < 1024; a++) begin
      do_read(25'(a), w, r, t);
      check($sformatf("seq_din_%0h", a), 32'(ioctl_din), 32'(mem[a]));
      check($sformatf("seq_pause_%0h", a), 32'(pause_cpu), 32'h1);
      if (t) check($sformatf("seq_tmo_%0h", a), 32'(t), 32'h0);
    end

    // Upload falls while a read is in flight
    ioctl_rd     = 1'b1;
    ioctl_addr   = 25'h012;
    tick();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    check("drain_wait_inflight", 32'(ioctl_wait), 32'h1);
    t = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ioctl_wait) begin
        t = 1'b0;
        break;
      end
    end
    check("drain_tmo", 32'(t), 32'h0);
    check("drain_din", 32'(ioctl_din), 32'hA5);
    seen = 1'b0;
    dly  = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (upload_done) begin
        seen = 1'b1;
        dly  = k;
        check("done_pause", 32'(pause_cpu), 32'h0);
        check("done_busy",  32'(busy), 32'h0);
        break;
      end
    end
    check("done_seen", 32'(seen), 32'h1);
    check("done_delay_le2", 32'(dly >= 1 && dly <= 2), 32'h1);
    tick();
    check("done_one_pulse", 32'(upload_done), 32'h0);

    // Strobe in IDLE is ignored
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h000;
    tick();
    ioctl_rd = 1'b0;
    check("idle_wait",  32'(ioctl_wait), 32'h0);
    check("idle_ramrd", 32'(ram_rd), 32'h0);
    tick();
    check("idle_din",   32'(ioctl_din), 32'hA5);
    check("idle_busy",  32'(busy), 32'h0);

    // Reset in the middle of a read
    ioctl_upload = 1'b1;
    repeat (8) tick();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h012;
    tick();
    ioctl_rd = 1'b0;
    check("mid_wait_before", 32'(ioctl_wait), 32'h1);
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    tick();
    check("mid_pause", 32'(pause_cpu), 32'h0);
    check("mid_wait",  32'(ioctl_wait), 32'h0);
    check("mid_busy",  32'(busy), 32'h0);
    check("mid_done",  32'(upload_done), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_done_after", 32'(upload_done), 32'h0);
    check("mid_busy_after", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
